// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial byte receiver with a two-flop input synchroniser,
// mid-bit sampling, a one-cycle valid strobe for good frames and a one-cycle
// frame_error strobe when the stop bit is low. After a framing error the
// receiver waits for the line to return high so a break or a stuck-low line
// cannot produce a stream of bogus bytes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state, state_next;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic [7:0]    data_next;
  logic          valid_next;
  logic          frame_error_next;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  // so a reset never looks like a start bit.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the values from before the clock edge, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];

  // State, counters, shift register and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shreg       <= shreg_next;
      data        <= data_next;
      valid       <= valid_next;
      frame_error <= frame_error_next;
    end
  end

  // Next-state logic: start-bit qualification, mid-bit sampling, stop check.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next       = state;
    cnt_next         = cnt;
    bit_idx_next     = bit_idx;
    shreg_next       = shreg;
    data_next        = data;
    valid_next       = 1'b0;
    frame_error_next = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_next = S_IDLE;
          end else begin
            bit_idx_next = '0;
            state_next   = S_DATA;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          // Shift right with the new bit entering at the top: LSB arrives first.
          shreg_next = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            // Leaving at mid stop bit means the next start edge is never missed.
            data_next  = shreg;
            valid_next = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = S_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Every cycle's pin values are recorded,
// a frame-level receiver model computes the expected outputs from the line
// history with sample-point arithmetic, and every cycle is compared. A set
// of hand-computed scenario expectations pins both the DUT and the model.
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  localparam int MAXC = 20000;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Recorded line inputs and DUT outputs, indexed by cycle number.
  bit         rec_rx  [MAXC];
  bit         rec_rst [MAXC];
  logic       out_valid [MAXC];
  logic       out_fe    [MAXC];
  logic       out_busy  [MAXC];
  logic [7:0] out_data  [MAXC];

  // Model expectations.
  bit         exp_valid [MAXC];
  bit         exp_fe    [MAXC];
  bit         exp_busy  [MAXC];
  bit         rst_eff   [MAXC];
  bit         set_flag  [MAXC];
  logic [7:0] set_val   [MAXC];
  logic [7:0] exp_data  [MAXC];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (cyc < MAXC) begin
      rec_rx[cyc]    = rx;
      rec_rst[cyc]   = reset;
      out_valid[cyc] = valid;
      out_fe[cyc]    = frame_error;
      out_busy[cyc]  = busy;
      out_data[cyc]  = data;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic rst);
    rx    = r;
    reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // One 10-bit frame; rst_at >= 0 pulses reset for one cycle at that offset.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10 * C; i++) drive(bits[i / C], (i == rst_at));
  endtask

  // ---------------- trace query helpers ----------------
  function automatic int count_valid(input int a, input int b);
    int c = 0;
    for (int m = a; m <= b && m < MAXC; m++) if (out_valid[m] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_fe(input int a, input int b);
    int c = 0;
    for (int m = a; m <= b && m < MAXC; m++) if (out_fe[m] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int c = 0;
    for (int m = a; m <= b && m < MAXC; m++) if (out_busy[m] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_valid(input int a, input int b);
    for (int m = a; m <= b && m < MAXC; m++) if (out_valid[m] === 1'b1) return m;
    return -1;
  endfunction

  function automatic int first_fe(input int a, input int b);
    for (int m = a; m <= b && m < MAXC; m++) if (out_fe[m] === 1'b1) return m;
    return -1;
  endfunction

  function automatic int dat(input int i);
    if (i < 0 || i >= MAXC) return -1;
    return int'(out_data[i]);
  endfunction

  function automatic int bsy(input int i);
    if (i < 0 || i >= MAXC) return -1;
    return int'(out_busy[i]);
  endfunction

  // ---------------- behavioural model ----------------
  // Synchronised line value seen by the receiver in cycle n: the pin two
  // cycles earlier, or idle-high for two cycles after a reset cycle.
  function automatic bit rs(input int n);
    if (n < 2) return 1'b1;
    if (rec_rst[n-1] || rec_rst[n-2]) return 1'b1;
    return rec_rx[n-2];
  endfunction

  function automatic int first_rst(input int a, input int b);
    for (int m = a; m <= b && m < MAXC; m++) if (rec_rst[m]) return m;
    return -1;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int m = a; m <= b && m < MAXC; m++) exp_busy[m] = 1'b1;
  endtask

  // Walks the line: a low level seen while idle opens a frame in the next
  // cycle (e); the start bit is judged on cycle e+HALF-1 and each later bit
  // one bit period further on; strobes appear the cycle after the stop sample.
  task automatic run_model(input int last);
    int n, e, st, sp, r, m;
    bit done;
    logic [7:0] b;
    n = 0;
    while (n < last) begin
      if (rec_rst[n]) begin
        rst_eff[n+1] = 1'b1;
        n++;
      end else if (rs(n)) begin
        n++;
      end else begin
        e  = n + 1;
        st = e + HALF - 1;
        sp = st + 9 * C;
        r  = first_rst(e, sp);
        if (r >= 0 && r <= st) begin
          mark_busy(e, r);
          n = r;
        end else if (rs(st)) begin
          mark_busy(e, st);
          n = st + 1;
        end else if (r >= 0) begin
          mark_busy(e, r);
          n = r;
        end else if (sp + 1 >= last) begin
          mark_busy(e, last - 1);
          n = last;
        end else begin
          for (int k = 0; k < 8; k++) b[k] = rs(st + (k + 1) * C);
          mark_busy(e, sp);
          if (rs(sp)) begin
            exp_valid[sp+1] = 1'b1;
            set_flag[sp+1]  = 1'b1;
            set_val[sp+1]   = b;
            n = sp + 1;
          end else begin
            exp_fe[sp+1] = 1'b1;
            m    = sp + 1;
            done = 1'b0;
            while (!done && m < last) begin
              if (rec_rst[m] || rs(m)) begin
                mark_busy(sp + 1, m);
                n    = rec_rst[m] ? m : m + 1;
                done = 1'b1;
              end else begin
                m++;
              end
            end
            if (!done) begin
              mark_busy(sp + 1, last - 1);
              n = last;
            end
          end
        end
      end
    end
    begin
      logic [7:0] cur;
      cur = 8'h00;
      for (int i = 1; i < last; i++) begin
        if (rst_eff[i])  cur = 8'h00;
        if (set_flag[i]) cur = set_val[i];
        exp_data[i] = cur;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f2, f3, f4, f5, h5, f5b, f6, r6, f6b, last;
    int v, v1, v2, v3, fe5, kind, c3_seen;

    rx = 1'b1;
    reset = 1'b1;
    rec_rx[0]  = 1'b1;
    rec_rst[0] = 1'b1;

    // 1. reset then 200 quiet cycles
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    idle(200);

    // 2. single byte
    f2 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    idle(20);

    // 3. back-to-back
    f3 = cyc;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);

    // 4. glitch
    f4 = cyc;
    hold_low(4);
    idle(30);

    // 5. framing error followed by a break, then recovery
    send_frame(8'h11, 1'b1, -1);
    idle(10);
    f5 = cyc;
    send_frame(8'h3C, 1'b0, -1);
    hold_low(64);
    h5 = cyc;
    idle(20);
    f5b = cyc;
    send_frame(8'h5A, 1'b1, -1);
    idle(20);

    // 6. reset during data bit 3; the receiver may re-frame the low tail of
    // the aborted byte once reset is released, which the model accounts for.
    f6 = cyc;
    r6 = f6 + 4 * C + HALF;
    send_frame(8'hC3, 1'b1, 4 * C + HALF);
    idle(200);
    f6b = cyc;
    send_frame(8'h96, 1'b1, -1);
    idle(20);

    // Randomised traffic: normal frames with random gaps, glitches,
    // framing errors with breaks, and resets at random points in a frame.
    for (int i = 0; i < 60 && cyc < MAXC - 800; i++) begin
      kind = int'($urandom_range(0, 15));
      if (kind == 0) begin
        hold_low(int'($urandom_range(1, 6)));
        idle(20);
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, -1);
        hold_low(int'($urandom_range(0, 40)));
        idle(20);
      end else if (kind == 2) begin
        send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 10 * C - 1)));
        idle(int'($urandom_range(0, 40)));
      end else begin
        send_frame(8'($urandom), 1'b1, -1);
        if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 30)));
      end
    end
    idle(250);
    last = cyc;

    run_model(last);

    // Literal expectations that pin the model.
    check("model_a5_valid", int'(exp_valid[f2 + 155]), 1);
    check("model_a5_data", int'(exp_data[f2 + 155]), 8'hA5);
    check("model_a5_busy_before", int'(exp_busy[f2 + 154]), 1);
    check("model_a5_busy_at", int'(exp_busy[f2 + 155]), 0);

    // Scenario 1: reset values and quiet line.
    check("s1_data", dat(3), 8'h00);
    check("s1_busy", bsy(3), 0);
    check("s1_valid_count", count_valid(1, 202), 0);
    check("s1_fe_count", count_fe(1, 202), 0);
    check("s1_busy_count", count_busy(1, 202), 0);

    // Scenario 2: single byte.
    v = first_valid(f2, f2 + 200);
    check_range("s2_latency", v - f2, 155, 157);
    check("s2_valid_count", count_valid(f2, f2 + 179), 1);
    check("s2_data", dat(v), 8'hA5);
    check("s2_busy_after", bsy(v + 1), 0);

    // Scenario 3: back-to-back.
    v1 = first_valid(f3, f3 + 200);
    v2 = first_valid(v1 + 1, v1 + 200);
    v3 = first_valid(v2 + 1, v2 + 200);
    check("s3_data0", dat(v1), 8'h00);
    check("s3_data1", dat(v2), 8'hFF);
    check("s3_data2", dat(v3), 8'h3C);
    check("s3_gap01", v2 - v1, 160);
    check("s3_gap12", v3 - v2, 160);
    check("s3_fe_count", count_fe(f3, f3 + 499), 0);

    // Scenario 4: glitch.
    check("s4_valid_count", count_valid(f4, f4 + 33), 0);
    check("s4_fe_count", count_fe(f4, f4 + 33), 0);
    check_range("s4_busy_pulse", count_busy(f4, f4 + 11), 1, 12);
    check("s4_busy_end", bsy(f4 + 12), 0);

    // Scenario 5: framing error.
    check("s5_data_before", dat(f5), 8'h11);
    fe5 = first_fe(f5, h5);
    check("s5_fe_count", count_fe(f5, h5 + 10), 1);
    check("s5_valid_count", count_valid(f5, h5 + 10), 0);
    check("s5_data_kept", dat(h5 + 10), 8'h11);
    check("s5_busy_held", count_busy(fe5, h5), h5 - fe5 + 1);
    check("s5_busy_released", bsy(h5 + 5), 0);
    v = first_valid(f5b, f5b + 200);
    check("s5_recover_data", dat(v), 8'h5A);

    // Scenario 6: reset mid-byte.
    check("s6_no_early_strobe", count_valid(r6 + 1, r6 + 150), 0);
    check("s6_fe_count", count_fe(f6, f6b - 1), 0);
    c3_seen = 0;
    for (int m = f6; m < f6b; m++) if (out_valid[m] === 1'b1 && out_data[m] === 8'hC3) c3_seen++;
    check("s6_no_c3", c3_seen, 0);
    check("s6_data_after_reset", dat(r6 + 2), 8'h00);
    v = first_valid(f6b, f6b + 200);
    check("s6_next_data", dat(v), 8'h96);

    // Cycle-by-cycle comparison against the model.
    for (int n = 1; n < last; n++) begin
      n_cmp++;
      if (out_valid[n] !== exp_valid[n] || out_fe[n] !== exp_fe[n] ||
          out_busy[n] !== exp_busy[n] || out_data[n] !== exp_data[n]) begin
        n_bad++;
        $display("FAIL trace cycle %0d: got valid=%b fe=%b busy=%b data=%h, want valid=%b fe=%b busy=%b data=%h",
                 n, out_valid[n], out_fe[n], out_busy[n], out_data[n],
                 exp_valid[n], exp_fe[n], exp_busy[n], exp_data[n]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
